// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage data-memory controller; each 32-bit access is split into
// two 16-bit accesses (low half, then high half) on an asynchronous SRAM.
// Latency: ready is low for WAIT_CYCLES cycles, then high for one DONE cycle.
// Backpressure: ready = ~req | DONE; the pipeline freezes while ready is low.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   rd_en, wr_en      load / store request, held until ready (read wins if both)
//   address           byte address; SRAM word 0 sits at ADDR_BASE
//   write_data        store data
//   read_data         load data, combinational {hi,lo} during DONE, then registered
//   ready             low while a request is pending and not finishing
//   SRAM_*            external SRAM pins; CE/OE/UB/LB are permanently enabled
module sram_ctrl #(
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   inout  wire  [15:0]        SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_t;

   // WAIT lasts WAIT_CYCLES-3 cycles; cnt runs 0..CNT_LAST inside it.
   localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 3) ? 4'(WAIT_CYCLES - 4) : 4'd0;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               rd_op_q, rd_op_d;
   logic [SRAM_AW-2:0] wa_q, wa_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [15:0]        lo_q, lo_d;
   logic [15:0]        hi_q, hi_d;
   logic [31:0]        rdata_q, rdata_d;

   logic               req;
   logic [31:0]        diff;
   logic [SRAM_AW-2:0] wa_in;
   logic               we_n;
   logic               dq_oe;
   logic [15:0]        dq_out;

   assign req   = rd_en | wr_en;
   // Wraps mod 2^32; addresses below ADDR_BASE simply alias high SRAM words.
   assign diff  = address - 32'(ADDR_BASE);
   assign wa_in = diff[SRAM_AW:2];

   // Byte offset and address bits above the SRAM window are intentionally dropped.
   logic unused_diff;
   assign unused_diff = ^{diff[31:SRAM_AW+1], diff[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_op_d = rd_op_q;
      wa_d    = wa_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      rdata_d = rdata_q;
      we_n    = 1'b1;
      dq_oe   = 1'b0;
      dq_out  = 16'h0000;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_LO;
               cnt_d   = 4'd0;
               rd_op_d = rd_en;
               wa_d    = wa_in;
               wdata_d = write_data;
               // Address is registered so it is already stable for the whole LO cycle.
               addr_d  = {wa_in, 1'b0};
            end
         end
         S_LO: begin
            we_n    = rd_op_q;
            dq_oe   = ~rd_op_q;
            dq_out  = wdata_q[15:0];
            if (rd_op_q) lo_d = SRAM_DQ;
            addr_d  = {wa_q, 1'b1};
            state_d = S_HI;
         end
         S_HI: begin
            we_n    = rd_op_q;
            dq_oe   = ~rd_op_q;
            dq_out  = wdata_q[31:16];
            if (rd_op_q) hi_d = SRAM_DQ;
            state_d = (WAIT_CYCLES > 3) ? S_WAIT : S_DONE;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            if (rd_op_q) rdata_d = {hi_q, lo_q};
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rd_op_q <= 1'b0;
         wa_q    <= '0;
         wdata_q <= 32'h0;
         addr_q  <= '0;
         lo_q    <= 16'h0000;
         hi_q    <= 16'h0000;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_op_q <= rd_op_d;
         wa_q    <= wa_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         rdata_q <= rdata_d;
      end
   end

   // Load data bypasses the register in DONE so MEM/WB captures it on the DONE edge.
   assign read_data = (state_q == S_DONE && rd_op_q) ? {hi_q, lo_q} : rdata_q;
   assign ready     = ~req | (state_q == S_DONE);
   assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
   assign SRAM_ADDR = addr_q;
   assign SRAM_WE_N = we_n;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: drives two sram_ctrl instances (WAIT_CYCLES=5 and 3), each with
// its own behavioural asynchronous SRAM, and checks them against a word-level model.
module tb_sram_ctrl;
   localparam int unsigned BASE = 1024;
   localparam int unsigned W0   = 5;
   localparam int unsigned W1   = 3;
   localparam int unsigned AW0  = 18;
   localparam int unsigned AW1  = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rd0, wr0, rd1, wr1;
   logic [31:0] ad0, wd0, ad1, wd1;
   wire  [31:0] rdat0, rdat1;
   wire         rdy0, rdy1;
   wire  [15:0] dq0, dq1;
   wire  [AW0-1:0] sa0;
   wire  [AW1-1:0] sa1;
   wire  we0, ce0, oe0, ub0, lb0;
   wire  we1, ce1, oe1, ub1, lb1;

   sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(W0), .SRAM_AW(AW0)) u_dut0 (
      .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(ad0), .write_data(wd0),
      .read_data(rdat0), .ready(rdy0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we0),
      .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0));

   sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(W1), .SRAM_AW(AW1)) u_dut1 (
      .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(ad1), .write_data(wd1),
      .read_data(rdat1), .ready(rdy1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1), .SRAM_WE_N(we1),
      .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1));

   // Asynchronous SRAMs: output enabled whenever not writing.
   logic [15:0] mem0 [0:(1<<AW0)-1];
   logic [15:0] mem1 [0:(1<<AW1)-1];
   assign dq0 = we0 ? mem0[sa0] : 16'hzzzz;
   assign dq1 = we1 ? mem1[sa1] : 16'hzzzz;
   always @(posedge clk) begin
      if (!we0) mem0[sa0] <= dq0;
      if (!we1) mem1[sa1] <= dq1;
   end

   int checks = 0;
   int errors = 0;

   // Word-level reference model: 32-bit words keyed by word index.
   logic [31:0] mdl [int unsigned];
   logic [31:0] waddrs [$];
   logic [31:0] exp_rdq [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int unsigned wa_of(input logic [31:0] a, input int unsigned aw);
      logic [31:0] off;
      off = a - 32'(BASE);
      return int'((off / 32'd4) % (32'd1 << (aw - 1)));
   endfunction

   task automatic drive(input int inst, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (inst == 0) begin rd0 = rd; wr0 = wr; ad0 = a; wd0 = d; end
      else           begin rd1 = rd; wr1 = wr; ad1 = a; wd1 = d; end
   endtask

   // Called just after a rising edge; that cycle becomes cycle 0 of the access.
   task automatic access(input int inst, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic [31:0] exp_we,
                         input string nm);
      int unsigned wa;
      int          lat;
      int          exp_lat;
      logic [31:0] mask;
      bit          done;
      logic [AW0-1:0] ix0;
      logic [AW1-1:0] ix1;
      wa      = wa_of(a, (inst != 0) ? AW1 : AW0);
      exp_lat = (inst != 0) ? int'(W1) : int'(W0);
      drive(inst, rd, wr, a, d);
      lat  = -1;
      mask = 32'h0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (c == 0)
            chk({nm, " held read_data"}, (inst != 0) ? rdat1 : rdat0, exp_rdq[inst]);
         if (((inst != 0) ? we1 : we0) == 1'b0) begin
            if (c < 32) mask[c] = 1'b1;
            chk({nm, " write addr"}, (inst != 0) ? 32'(sa1) : 32'(sa0),
                32'(wa * 2 + ((c >= 2) ? 1 : 0)));
            chk({nm, " write dq"}, (inst != 0) ? 32'(dq1) : 32'(dq0),
                (c >= 2) ? 32'(d[31:16]) : 32'(d[15:0]));
         end
         if ((inst != 0) ? rdy1 : rdy0) begin
            lat  = c;
            done = 1'b1;
            if (rd) chk({nm, " done read_data"}, (inst != 0) ? rdat1 : rdat0, exp_rd);
         end
      end
      chk({nm, " ready-low cycles"}, 32'(lat), 32'(exp_lat));
      chk({nm, " WE_N low cycles"}, mask, exp_we);
      if (rd) exp_rdq[inst] = exp_rd;
      @(posedge clk); #1;
      if (!rd) begin
         ix0 = AW0'(wa * 2);
         ix1 = AW1'(wa * 2);
         if (inst == 0) begin
            chk({nm, " sram lo"}, 32'(mem0[ix0]), 32'(d[15:0]));
            chk({nm, " sram hi"}, 32'(mem0[ix0 + 1'b1]), 32'(d[31:16]));
         end else begin
            chk({nm, " sram lo"}, 32'(mem1[ix1]), 32'(d[15:0]));
            chk({nm, " sram hi"}, 32'(mem1[ix1 + 1'b1]), 32'(d[31:16]));
         end
      end
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle ready0", 32'(rdy0), 32'h1);
         chk("idle we_n0", 32'(we0), 32'h1);
         chk("idle ready1", 32'(rdy1), 32'h1);
         chk("idle we_n1", 32'(we1), 32'h1);
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [31:0] exp_we;
   } vec_t;

   vec_t vt [12];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{1'b0, 1'b1, 32'd1040,   32'h5555AAAA, 32'h0,        32'h6};
      vt[1]  = '{1'b0, 1'b1, 32'd1024,   32'hDEADBEEF, 32'h0,        32'h6};
      vt[2]  = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 32'h0};
      vt[3]  = '{1'b0, 1'b1, 32'd1036,   32'h12345678, 32'h0,        32'h6};
      vt[4]  = '{1'b1, 1'b0, 32'd1036,   32'h0,        32'h12345678, 32'h0};
      vt[5]  = '{1'b1, 1'b1, 32'd1040,   32'hFFFFFFFF, 32'h5555AAAA, 32'h0};
      vt[6]  = '{1'b1, 1'b0, 32'd1040,   32'h0,        32'h5555AAAA, 32'h0};
      vt[7]  = '{1'b1, 1'b0, 32'd1027,   32'h0,        32'hDEADBEEF, 32'h0};
      vt[8]  = '{1'b0, 1'b1, 32'd525312, 32'h0F0F0F0F, 32'h0,        32'h6};
      vt[9]  = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'h0F0F0F0F, 32'h0};
      vt[10] = '{1'b0, 1'b1, 32'd1020,   32'h13579BDF, 32'h0,        32'h6};
      vt[11] = '{1'b1, 1'b0, 32'd1020,   32'h0,        32'h13579BDF, 32'h0};

      rst = 1'b0;
      drive(0, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
      exp_rdq[0] = 32'h0;
      exp_rdq[1] = 32'h0;
      #1;
      chk("reset read_data", rdat0, 32'h0);
      chk("reset we_n", 32'(we0), 32'h1);
      chk("reset sram_addr", 32'(sa0), 32'h0);
      chk("reset ready", 32'(rdy0), 32'h1);
      chk("tied ce/oe/ub/lb", 32'({ce0, oe0, ub0, lb0, ce1, oe1, ub1, lb1}), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Directed table, applied back-to-back with no idle gap.
      for (int i = 0; i < 12; i++) begin
         access(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].exp_rd, vt[i].exp_we,
                $sformatf("vec%0d", i));
         if (vt[i].wr && !vt[i].rd) begin
            mdl[wa_of(vt[i].addr, AW0)] = vt[i].wd;
            waddrs.push_back(vt[i].addr);
         end
      end
      chk("sram[6]", 32'(mem0[6]), 32'h5678);
      chk("sram[7]", 32'(mem0[7]), 32'h1234);
      chk("sram[8]", 32'(mem0[8]), 32'hAAAA);
      chk("sram[9]", 32'(mem0[9]), 32'h5555);
      idle(2);

      // Reset in cycle 3 of a write, request held across reset.
      drive(0, 0, 1, 32'd1024, 32'hCAFEF00D);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst read_data", rdat0, 32'h0);
      chk("midrst we_n", 32'(we0), 32'h1);
      chk("midrst sram_addr", 32'(sa0), 32'h0);
      chk("midrst ready", 32'(rdy0), 32'h0);
      exp_rdq[0] = 32'h0;
      exp_rdq[1] = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      access(0, 0, 1, 32'd1024, 32'hCAFEF00D, 32'h0, 32'h6, "rst restart");
      mdl[0] = 32'hCAFEF00D;
      idle(1);

      // Randomised traffic against the word model.
      for (int i = 0; i < 160; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         int unsigned wa;
         d = $urandom();
         if ($urandom_range(0, 9) < 4) begin
            a  = waddrs[$urandom_range(0, waddrs.size() - 1)];
            wa = wa_of(a, AW0);
            access(0, 1, bit'($urandom_range(0, 1)), a, d, mdl[wa], 32'h0,
                   $sformatf("rnd%0d rd", i));
         end else begin
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            wa = wa_of(a, AW0);
            access(0, 0, 1, a, d, 32'h0, 32'h6, $sformatf("rnd%0d wr", i));
            mdl[wa] = d;
            waddrs.push_back(a);
         end
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(1);

      // Minimum-latency instance: no WAIT state.
      access(1, 0, 1, BASE + 8, 32'h0BADCAFE, 32'h0, 32'h6, "w3 wr");
      access(1, 1, 0, BASE + 8, 32'h0, 32'h0BADCAFE, 32'h0, "w3 rd");
      access(1, 1, 1, BASE + 8, 32'h11111111, 32'h0BADCAFE, 32'h0, "w3 rdwr");
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
